uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Memory-mapped UART transmitter for the RV32I SoC. Sits downstream of the address decoder: when the core stores to the UART window, this block captures the byte into an 8-entry FIFO and serialises it onto the `uart_tx` pin as 8N1 frames at a software-programmable baud divisor. It also returns status and divisor readback to the core over the same data-memory bus.

## Interface
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, ≥2
- `DEFAULT_DIV`, 16'd867, reset value of the baud divisor (100 MHz / 115200 − 1)
- `clk`  in  1  system clock; all logic is on the rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `uart_en`  in  1  address decoder hit on the UART window
- `uart_addr`  in  `XLEN`  byte offset within the UART window; bits [3:2] are decoded
- `mem_wr_en`  in  1  core data write strobe
- `mem_rd_en`  in  1  core data read strobe
- `uart_tx_data`  in  `XLEN`  core write data
- `uart_rd_data`  out  `XLEN`  register read data
- `uart_tx`  out  1  serial output, idle high
- `tx_irq`  out  1  high while the FIFO is empty and the shifter is idle

## Operation
- Register map (offset [3:2]):
  - 0x0 TXDATA: write pushes `uart_tx_data[7:0]`. Reads return 0.
  - 0x4 STATUS: read-only bits except the sticky bit.
    - bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky).
    - bits[7:4] FIFO count.
    - Any write to STATUS clears overflow.
  - 0x8 BAUD_DIV: read/write, bits[15:0]. Upper bits read 0.
  - 0xC reserved: reads 0, writes are ignored.
- Access is qualified by `uart_en`. Strobes without `uart_en` are ignored.
- FIFO:
  - Circular buffer with read and write pointers, plus a count of width log2(FIFO_DEPTH)+1.
  - Pointers wrap modulo FIFO_DEPTH.
  - Full is evaluated before any same-cycle pop. A push while full is dropped and sets overflow, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle on a non-full FIFO leave the count unchanged.
- Transmit FSM states:
  - IDLE: if the FIFO is not empty, pop into the shift register, clear the baud counter, go to START.
  - START: `uart_tx`=0 for one bit period, then DATA with bit index 0.
  - DATA: drive `shift[idx]` (LSB first). After the 8th bit go to PARITY if compiled in, otherwise STOP.
  - PARITY: drive the even-parity bit (XOR of the 8 data bits) for one bit period.
  - STOP: `uart_tx`=1 for one bit period, then IDLE.
- Baud timing:
  - A 16-bit counter increments each clock. A bit ends when counter ≥ BAUD_DIV; the counter then resets to 0.
  - Bit period is BAUD_DIV+1 clocks. BAUD_DIV=0 gives 1 clock per bit.
  - Changing BAUD_DIV mid-frame takes effect immediately because the comparison uses the live value. A new value at or below the current count ends the current bit on the next clock.
- busy = FSM not in IDLE.

## Timing
- Reset values:
  - `uart_tx`=1, `uart_rd_data`=0, `tx_irq`=1.
  - FSM in IDLE, FIFO empty, pointers 0, overflow 0, BAUD_DIV=DEFAULT_DIV.
- Reset asserted mid-frame aborts immediately: `uart_tx` goes high asynchronously and the FIFO contents are discarded.
- Read latency is one cycle. `uart_rd_data` is registered on the edge where `uart_en && mem_rd_en`, and holds its value until the next read.
- Write-to-line latency from an idle, empty state:
  - Write accepted at edge N; count = 1 after N.
  - FSM pops at edge N+1.
  - `uart_tx` falls after edge N+2.
- Back-to-back frames: after STOP completes, the next START begins within one clock (via IDLE) when the FIFO is not empty.
- `tx_irq` is registered and deasserts the cycle after the first push.
- Simultaneous read and write strobes: the write takes effect, and the read returns the pre-write register value.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- When defined:
  - The PARITY state is compiled in and frames are 8E1 (11 bit periods).
  - STATUS bit8 reads 1.
- When undefined:
  - The PARITY state is absent and frames are 8N1 (10 bit periods).
  - STATUS bit8 reads 0.

## Test plan
- Reset then idle: `rst_n` low for 5 clocks -> `uart_tx`=1, `tx_irq`=1, STATUS read = 0x02, BAUD_DIV read = 867.
- Single byte, BAUD_DIV=3: write 0xA5 to 0x0 -> `uart_tx` falls 2 clocks later; line pattern 0,1,0,1,0,0,1,0,1,1 with each bit held 4 clocks; `tx_irq` returns to 1 after stop.
- Overflow, BAUD_DIV=100: 10 consecutive writes to TXDATA -> STATUS shows full=1, count=8, overflow=1; exactly 9 frames are sent (1 in the shifter + 8 in the FIFO); a write to 0x4 clears overflow.
- FIFO wrap: 20 writes of 0x00..0x13, each issued only when not full -> 20 frames on the line in order, with no drops and overflow staying 0.
- Mid-frame divisor change: BAUD_DIV=10, write 0x55, set BAUD_DIV=2 during DATA bit 3 -> the current bit ends within 1 clock and the remaining bits are 3 clocks each.
- Async reset mid-frame: assert `rst_n` during DATA with 3 bytes queued -> `uart_tx`=1 without waiting for a clock edge; after release, STATUS=0x02 and no further frames are sent. With `UART_TX_PARITY_EN` defined, the 0xA5 frame carries parity bit 0.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: memory-mapped UART transmitter, TX FIFO + 8N1 serialiser.
// Define UART_TX_PARITY_EN to build 8E1 frames (even parity bit).
module uart_tx_ctrl #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867,
  parameter int          XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            uart_en,
  input  logic [XLEN-1:0] uart_addr,
  input  logic            mem_wr_en,
  input  logic            mem_rd_en,
  input  logic [XLEN-1:0] uart_tx_data,
  output logic [XLEN-1:0] uart_rd_data,
  output logic            uart_tx,
  output logic            tx_irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;

  state_t r_state, w_next;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_count, w_cnt_next;
  logic            r_ovf;
  logic [15:0]     r_div, r_baud;
  logic [7:0]      r_shift;
  logic [2:0]      r_idx;
  logic            r_tx, r_irq;
  logic [XLEN-1:0] r_rd, w_rdata;

  logic       w_wr, w_rd, w_push, w_push_ok, w_pop;
  logic       w_full, w_empty, w_busy, w_tick, w_tx;
  logic [1:0] w_off;
  logic [3:0] w_cnt4;
  logic [8:0] w_stat;
  logic       w_unused;

  assign w_off     = uart_addr[3:2];
  assign w_wr      = uart_en & mem_wr_en;
  assign w_rd      = uart_en & mem_rd_en;
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = w_wr & (w_off == 2'd0);
  assign w_push_ok = w_push & ~w_full;
  assign w_busy    = (r_state != S_IDLE);
  assign w_tick    = (r_baud >= r_div);
  assign w_cnt4    = 4'(r_count);
  assign w_stat    = {PAR_EN, w_cnt4, r_ovf, w_busy, w_empty, w_full};
  assign w_unused  = ^{uart_addr[XLEN-1:4], uart_addr[1:0],
                       uart_tx_data[XLEN-1:16]};

  assign uart_rd_data = r_rd;
  assign uart_tx      = r_tx;
  assign tx_irq       = r_irq;

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_tx   = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_START;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_tick) w_next = S_DATA;
      end
      S_DATA: begin
        w_tx = r_shift[r_idx];
        if (w_tick && r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          w_next = S_PAR;
`else
          w_next = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PAR: begin
        w_tx = ^r_shift;
        if (w_tick) w_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_tick) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_next = r_count;
    if (w_push_ok && !w_pop)
      w_cnt_next = r_count + CW'(1);
    else if (!w_push_ok && w_pop)
      w_cnt_next = r_count - CW'(1);
  end

  always_comb begin
    w_rdata = '0;
    unique case (w_off)
      2'd0: w_rdata = '0;
      2'd1: w_rdata = XLEN'(w_stat);
      2'd2: w_rdata = XLEN'(r_div);
      2'd3: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp] <= uart_tx_data[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_div   <= DEFAULT_DIV;
      r_baud  <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_tx    <= 1'b1;
      r_irq   <= 1'b1;
      r_rd    <= '0;
    end else begin
      r_state <= w_next;
      r_count <= w_cnt_next;
      r_tx    <= w_tx;
      r_irq   <= (w_cnt_next == '0) && (w_next == S_IDLE);
      if (w_push_ok) r_wp <= r_wp + PW'(1);
      if (w_wr && w_off == 2'd1)
        r_ovf <= 1'b0;
      else if (w_push && w_full)
        r_ovf <= 1'b1;
      if (w_wr && w_off == 2'd2) r_div <= uart_tx_data[15:0];
      if (w_rd) r_rd <= w_rdata;
      if (w_pop) begin
        r_rp    <= r_rp + PW'(1);
        r_shift <= r_mem[r_rp];
        r_baud  <= '0;
        r_idx   <= '0;
      end else if (w_busy) begin
        // live divisor compare: a lowered divisor ends the bit next clock
        r_baud <= w_tick ? 16'd0 : r_baud + 16'd1;
        if (r_state == S_DATA && w_tick) r_idx <= r_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed self-checking bench for uart_tx_ctrl.
// Build with UART_TX_PARITY_EN defined to check the 8E1 variant.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
  localparam logic [31:0] IDLE_ST = 32'h102;
  localparam logic [31:0] PBIT    = 32'h100;
`else
  localparam logic [31:0] IDLE_ST = 32'h002;
  localparam logic [31:0] PBIT    = 32'h000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_en = 1'b0;
  logic        mem_wr_en = 1'b0;
  logic        mem_rd_en = 1'b0;
  logic [31:0] uart_addr = '0;
  logic [31:0] uart_tx_data = '0;
  logic [31:0] uart_rd_data;
  logic        uart_tx;
  logic        tx_irq;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_en      (uart_en),
    .uart_addr    (uart_addr),
    .mem_wr_en    (mem_wr_en),
    .mem_rd_en    (mem_rd_en),
    .uart_tx_data (uart_tx_data),
    .uart_rd_data (uart_rd_data),
    .uart_tx      (uart_tx),
    .tx_irq       (tx_irq)
  );

  always #5 clk = ~clk;

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    uart_en = 1'b1; mem_wr_en = 1'b1;
    uart_addr = a; uart_tx_data = d;
    @(negedge clk);
    uart_en = 1'b0; mem_wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] q);
    @(negedge clk);
    uart_en = 1'b1; mem_rd_en = 1'b1; uart_addr = a;
    @(negedge clk);
    uart_en = 1'b0; mem_rd_en = 1'b0;
    q = uart_rd_data;
  endtask

  task automatic bus_rw(input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] q);
    @(negedge clk);
    uart_en = 1'b1; mem_rd_en = 1'b1; mem_wr_en = 1'b1;
    uart_addr = a; uart_tx_data = d;
    @(negedge clk);
    uart_en = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
    q = uart_rd_data;
  endtask

  // mid-bit sampling receiver; must be entered on a falling clock edge
  task automatic rx_frame(input int div, input int tmo,
                          output logic [7:0] b, output logic p,
                          output logic s, output logic to);
    int w;
    w = 0; b = '0; p = 1'b0; s = 1'b0; to = 1'b0;
    while (uart_tx !== 1'b0 && w < tmo) begin
      @(negedge clk);
      w++;
    end
    if (uart_tx !== 1'b0) begin
      to = 1'b1;
      return;
    end
    repeat (div / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (div + 1) @(negedge clk);
      b[i] = uart_tx;
    end
`ifdef UART_TX_PARITY_EN
    repeat (div + 1) @(negedge clk);
    p = uart_tx;
`endif
    repeat (div + 1) @(negedge clk);
    s = uart_tx;
  endtask

  task automatic test_reset;
    logic [31:0] q;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (uart_tx !== 1'b1) begin
      n_bad++; $display("FAIL reset_tx got %b want 1", uart_tx);
    end
    n_cmp++;
    if (tx_irq !== 1'b1) begin
      n_bad++; $display("FAIL reset_irq got %b want 1", tx_irq);
    end
    n_cmp++;
    if (uart_rd_data !== 32'h0) begin
      n_bad++; $display("FAIL reset_rd got %h want 0", uart_rd_data);
    end
    bus_rd(32'h4, q);
    n_cmp++;
    if (q !== IDLE_ST) begin
      n_bad++; $display("FAIL reset_status got %h want %h", q, IDLE_ST);
    end
    bus_rd(32'h8, q);
    n_cmp++;
    if (q !== 32'd867) begin
      n_bad++; $display("FAIL reset_div got %0d want 867", q);
    end
  endtask

  task automatic test_regs;
    logic [31:0] q;
    bus_wr(32'h8, 32'hFFFF_0005);
    bus_rd(32'h8, q);
    n_cmp++;
    if (q !== 32'h5) begin
      n_bad++; $display("FAIL div_upper got %h want 5", q);
    end
    bus_rw(32'h8, 32'h7, q);
    n_cmp++;
    if (q !== 32'h5) begin
      n_bad++; $display("FAIL rw_old got %h want 5", q);
    end
    bus_rd(32'h8, q);
    n_cmp++;
    if (q !== 32'h7) begin
      n_bad++; $display("FAIL rw_new got %h want 7", q);
    end
    bus_wr(32'hC, 32'h1234);
    bus_rd(32'hC, q);
    n_cmp++;
    if (q !== 32'h0) begin
      n_bad++; $display("FAIL rsvd_rd got %h want 0", q);
    end
    bus_rd(32'h0, q);
    n_cmp++;
    if (q !== 32'h0) begin
      n_bad++; $display("FAIL txdata_rd got %h want 0", q);
    end
    @(negedge clk);
    uart_en = 1'b0; mem_wr_en = 1'b1;
    uart_addr = 32'h8; uart_tx_data = 32'h9;
    @(negedge clk);
    mem_wr_en = 1'b0;
    bus_rd(32'h8, q);
    n_cmp++;
    if (q !== 32'h7) begin
      n_bad++; $display("FAIL no_en_wr got %h want 7", q);
    end
    bus_rd(32'h4, q);
    n_cmp++;
    if (q !== IDLE_ST) begin
      n_bad++; $display("FAIL regs_status got %h want %h", q, IDLE_ST);
    end
  endtask

  task automatic test_single_byte;
    logic [10:0] pat;
    int nb;
`ifdef UART_TX_PARITY_EN
    pat = {1'b1, 1'b0, 8'hA5, 1'b0};
    nb = 11;
`else
    pat = {1'b0, 1'b1, 8'hA5, 1'b0};
    nb = 10;
`endif
    bus_wr(32'h8, 32'd3);
    bus_wr(32'h0, 32'hA5);
    n_cmp++;
    if (tx_irq !== 1'b0) begin
      n_bad++; $display("FAIL sb_irq_low got %b want 0", tx_irq);
    end
    n_cmp++;
    if (uart_tx !== 1'b1) begin
      n_bad++; $display("FAIL sb_lat0 got %b want 1", uart_tx);
    end
    @(negedge clk);
    n_cmp++;
    if (uart_tx !== 1'b1) begin
      n_bad++; $display("FAIL sb_lat1 got %b want 1", uart_tx);
    end
    for (int k = 0; k < nb * 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (uart_tx !== pat[k/4]) begin
        n_bad++;
        $display("FAIL sb_bit%0d got %b want %b", k, uart_tx, pat[k/4]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (tx_irq !== 1'b1 || uart_tx !== 1'b1) begin
      n_bad++;
      $display("FAIL sb_done irq=%b tx=%b want 1/1", tx_irq, uart_tx);
    end
  endtask

  task automatic test_mid_div;
    logic smp [90];
    int   runs [16];
    int   exp_r [9];
    int   nr;
    int   w;
    exp_r = '{11, 11, 11, 11, 6, 3, 3, 3, 3};
`ifdef UART_TX_PARITY_EN
    exp_r[8] = 6;
`endif
    bus_wr(32'h8, 32'd10);
    bus_wr(32'h0, 32'h55);
    w = 0;
    while (uart_tx !== 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (uart_tx !== 1'b0) begin
      n_bad++; $display("FAIL md_start got %b want 0", uart_tx);
    end
    fork
      begin
        smp[0] = uart_tx;
        for (int j = 1; j < 90; j++) begin
          @(negedge clk);
          smp[j] = uart_tx;
        end
      end
      begin
        repeat (47) @(negedge clk);
        uart_en = 1'b1; mem_wr_en = 1'b1;
        uart_addr = 32'h8; uart_tx_data = 32'd2;
        @(negedge clk);
        uart_en = 1'b0; mem_wr_en = 1'b0;
      end
    join
    nr = 0;
    runs[0] = 1;
    for (int j = 1; j < 90; j++) begin
      if (smp[j] === smp[j-1])
        runs[nr]++;
      else if (nr < 15) begin
        nr++;
        runs[nr] = 1;
      end
    end
    for (int r = 0; r < 9; r++) begin
      n_cmp++;
      if (runs[r] !== exp_r[r]) begin
        n_bad++;
        $display("FAIL md_run%0d got %0d want %0d", r, runs[r], exp_r[r]);
      end
    end
    n_cmp++;
    if (nr !== 9 || smp[89] !== 1'b1 || runs[9] < 3) begin
      n_bad++;
      $display("FAIL md_stop runs=%0d last=%b want 10 runs ending high",
               nr + 1, smp[89]);
    end
  endtask

  task automatic test_overflow;
    logic [7:0]  rb [9];
    logic        rp [9];
    logic        rs [9];
    logic        rto [9];
    logic [31:0] q;
    int          lows;
    bus_wr(32'h8, 32'd100);
    @(negedge clk);
    uart_en = 1'b1; mem_wr_en = 1'b1; uart_addr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      uart_tx_data = 32'h10 + i;
      @(negedge clk);
    end
    uart_en = 1'b0; mem_wr_en = 1'b0;
    fork
      begin
        for (int f = 0; f < 9; f++)
          rx_frame(100, 3000, rb[f], rp[f], rs[f], rto[f]);
      end
      begin
        bus_rd(32'h4, q);
        n_cmp++;
        if (q !== (32'h8D | PBIT)) begin
          n_bad++;
          $display("FAIL ov_status got %h want %h", q, 32'h8D | PBIT);
        end
        bus_wr(32'h4, 32'h0);
        bus_rd(32'h4, q);
        n_cmp++;
        if (q !== (32'h85 | PBIT)) begin
          n_bad++;
          $display("FAIL ov_clear got %h want %h", q, 32'h85 | PBIT);
        end
      end
    join
    for (int f = 0; f < 9; f++) begin
      n_cmp++;
      if (rto[f] !== 1'b0 || rb[f] !== 8'(8'h10 + f) || rs[f] !== 1'b1) begin
        n_bad++;
        $display("FAIL ov_frame%0d got %h stop=%b to=%b want %h",
                 f, rb[f], rs[f], rto[f], 8'(8'h10 + f));
      end
`ifdef UART_TX_PARITY_EN
      n_cmp++;
      if (rp[f] !== ^rb[f]) begin
        n_bad++;
        $display("FAIL ov_par%0d got %b want %b", f, rp[f], ^rb[f]);
      end
`endif
    end
    lows = 0;
    repeat (500) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    n_cmp++;
    if (lows !== 0) begin
      n_bad++; $display("FAIL ov_extra got %0d low cycles want 0", lows);
    end
    bus_rd(32'h4, q);
    n_cmp++;
    if (q !== IDLE_ST) begin
      n_bad++; $display("FAIL ov_end got %h want %h", q, IDLE_ST);
    end
  endtask

  task automatic test_fifo_wrap;
    logic [7:0]  rb [20];
    logic        rp, rs;
    logic        rto [20];
    logic [31:0] st, q;
    int          sent, polls;
    bus_wr(32'h8, 32'd1);
    sent = 0;
    polls = 0;
    fork
      begin
        for (int f = 0; f < 20; f++)
          rx_frame(1, 2000, rb[f], rp, rs, rto[f]);
      end
      begin
        while (sent < 20 && polls < 3000) begin
          bus_rd(32'h4, st);
          polls++;
          if (!st[0]) begin
            bus_wr(32'h0, 32'(sent));
            sent++;
          end
        end
      end
    join
    n_cmp++;
    if (sent !== 20) begin
      n_bad++; $display("FAIL wr_sent got %0d want 20", sent);
    end
    for (int f = 0; f < 20; f++) begin
      n_cmp++;
      if (rto[f] !== 1'b0 || rb[f] !== 8'(f)) begin
        n_bad++;
        $display("FAIL wr_frame%0d got %h to=%b want %h",
                 f, rb[f], rto[f], 8'(f));
      end
    end
    repeat (30) @(negedge clk);
    bus_rd(32'h4, q);
    n_cmp++;
    if (q !== IDLE_ST) begin
      n_bad++; $display("FAIL wr_status got %h want %h", q, IDLE_ST);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] q;
    int          w, lows;
    bus_wr(32'h8, 32'd10);
    bus_wr(32'h0, 32'hA5);
    bus_wr(32'h0, 32'h3C);
    bus_wr(32'h0, 32'h0F);
    w = 0;
    while (uart_tx !== 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (25) @(negedge clk);
    n_cmp++;
    if (uart_tx !== 1'b0) begin
      n_bad++; $display("FAIL ar_pre got %b want 0", uart_tx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (uart_tx !== 1'b1 || tx_irq !== 1'b1) begin
      n_bad++;
      $display("FAIL ar_async tx=%b irq=%b want 1/1", uart_tx, tx_irq);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus_rd(32'h4, q);
    n_cmp++;
    if (q !== IDLE_ST) begin
      n_bad++; $display("FAIL ar_status got %h want %h", q, IDLE_ST);
    end
    bus_rd(32'h8, q);
    n_cmp++;
    if (q !== 32'd867) begin
      n_bad++; $display("FAIL ar_div got %0d want 867", q);
    end
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    n_cmp++;
    if (lows !== 0) begin
      n_bad++; $display("FAIL ar_quiet got %0d low cycles want 0", lows);
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_single_byte();
    test_mid_div();
    test_overflow();
    test_fifo_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
